// File: rtl/dmem_req_arbiter_pkg.sv
// Shared types and constants for the data-memory request arbiter.
package dmem_pkg;

    // Identifies which upstream path issued an accepted request.
    typedef enum logic {
        SRC_CACHED   = 1'b0,
        SRC_UNCACHED = 1'b1
    } src_id_t;

    // sram-like transfer size encodings.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Default depth of the outstanding-request tracker.
    localparam int unsigned DEF_MAX_OUTST = 4;

    // The master that is not s; used to advance the round-robin pointer.
    function automatic src_id_t other_src(input src_id_t s);
        return (s == SRC_CACHED) ? SRC_UNCACHED : SRC_CACHED;
    endfunction

endpackage

// File: rtl/dmem_req_arbiter_src_id_fifo.sv
// In-order FIFO recording the source of each accepted request.
module src_id_fifo
    import dmem_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = DEF_MAX_OUTST
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_req_arbiter.sv
// Merges the cached (m0) and uncached (m1) sram-like data streams onto one port.
module dmem_req_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned MAX_OUTST     = DEF_MAX_OUTST,
    parameter int unsigned PRIO_UNCACHED = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_addr_ok,
    output logic        m0_data_ok,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_addr_ok,
    output logic        m1_data_ok,
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    output logic        err_stray_ok
);

    localparam int unsigned CW       = $clog2(MAX_OUTST) + 1;
    localparam src_id_t     RR_RESET = (PRIO_UNCACHED != 0) ? SRC_UNCACHED : SRC_CACHED;

    logic          lock;
    src_id_t       lock_src;
    src_id_t       rr_ptr;
    logic          grant_valid;
    src_id_t       grant_src;
    logic          grant_req;
    logic          accept;
    logic          pop;
    logic [0:0]    head_bits;
    src_id_t       head_src;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    // Pick the master for this cycle: locked source, else sole requester, else rr_ptr.
    always_comb begin
        grant_valid = 1'b0;
        grant_src   = SRC_CACHED;
        if (lock) begin
            grant_valid = 1'b1;
            grant_src   = lock_src;
        end else if (m0_req && m1_req) begin
            grant_valid = 1'b1;
            grant_src   = rr_ptr;
        end else if (m1_req) begin
            grant_valid = 1'b1;
            grant_src   = SRC_UNCACHED;
        end else if (m0_req) begin
            grant_valid = 1'b1;
            grant_src   = SRC_CACHED;
        end
        if (fifo_full) begin
            grant_valid = 1'b0;
        end
    end

    // Forward the granted master's request fields; idle bus is all zeros.
    always_comb begin
        grant_req = 1'b0;
        s_wr      = 1'b0;
        s_size    = '0;
        s_addr    = '0;
        s_wdata   = '0;
        if (grant_valid) begin
            if (grant_src == SRC_UNCACHED) begin
                grant_req = m1_req;
                s_wr      = m1_wr;
                s_size    = m1_size;
                s_addr    = m1_addr;
                s_wdata   = m1_wdata;
            end else begin
                grant_req = m0_req;
                s_wr      = m0_wr;
                s_size    = m0_size;
                s_addr    = m0_addr;
                s_wdata   = m0_wdata;
            end
        end
    end

    assign s_req  = grant_valid & grant_req;
    assign accept = s_req & s_addr_ok;

    assign m0_addr_ok = accept & (grant_src == SRC_CACHED);
    assign m1_addr_ok = accept & (grant_src == SRC_UNCACHED);

    // Completions always belong to the oldest accepted request.
    assign head_src   = src_id_t'(head_bits);
    assign pop        = s_data_ok & (fifo_count != '0);
    assign m0_data_ok = pop & (head_src == SRC_CACHED);
    assign m1_data_ok = pop & (head_src == SRC_UNCACHED);
    assign m0_rdata   = m0_data_ok ? s_rdata : '0;
    assign m1_rdata   = m1_data_ok ? s_rdata : '0;

    src_id_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUTST)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (accept),
        .pop    (pop),
        .din    (grant_src),
        .head   (head_bits),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Hold the grant while a request waits for addr_ok; rotate priority on acceptance.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            lock         <= 1'b0;
            lock_src     <= SRC_CACHED;
            rr_ptr       <= RR_RESET;
            err_stray_ok <= 1'b0;
        end else begin
            if (accept) begin
                lock   <= 1'b0;
                rr_ptr <= other_src(grant_src);
            end else if (s_req) begin
                lock     <= 1'b1;
                lock_src <= grant_src;
            end
            if (s_data_ok && fifo_empty) begin
                err_stray_ok <= 1'b1;
            end
        end
    end

endmodule

// File: doc/dmem_req_arbiter.md
Name: dmem_req_arbiter

Overview:
- Merges the two sram-like data streams (cached refill/writeback traffic from d_cache, uncached traffic for the conf/MMIO path) into the single data port of cpu_axi_interface.
- Arbitrates requests and locks the selected address until it is accepted.
- Records the source of every accepted request in an in-order FIFO and routes each returned data_ok/rdata back to that source.

Parameters:
- MAX_OUTST, 4, maximum accepted-but-not-completed requests; power of 2, range 2..16.
- PRIO_UNCACHED, 1, 1 means m1 (uncached) wins ties when the round-robin pointer is reset; 0 means m0 wins.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  synchronous reset, active low.
- m0_req, m0_wr  in  1 each  cached-path request and write flag.
- m0_size  in  2  0=byte, 1=half, 2=word.
- m0_addr, m0_wdata  in  32 each  physical address and write data.
- m0_rdata  out  32  read data.
- m0_addr_ok, m0_data_ok  out  1 each  handshakes.
- m1_req, m1_wr, m1_size, m1_addr, m1_wdata, m1_rdata, m1_addr_ok, m1_data_ok  same directions and widths as m0_*, for the uncached path.
- s_req, s_wr  out  1 each  to cpu_axi_interface.
- s_size  out  2.
- s_addr, s_wdata  out  32 each.
- s_rdata  in  32.
- s_addr_ok, s_data_ok  in  1 each.
- err_stray_ok  out  1  sticky flag; set when s_data_ok arrives with the FIFO empty.

Behaviour:
- Reset (resetn=0 at a clock edge):
  - FIFO empty, count=0, lock=0, rr_ptr=PRIO_UNCACHED, err_stray_ok=0.
  - All outputs are combinational from this state, so with no request: s_req=0, all addr_ok/data_ok=0, rdata buses=0.
- Grant:
  - When lock=0 and only one master requests, that master is granted.
  - When lock=0 and both request, the master selected by rr_ptr is granted.
  - When lock=1, the granted master is held in lock_src.
  - No grant while count==MAX_OUTST.
- Slave drive: s_req = granted master's req AND count<MAX_OUTST. s_wr, s_size, s_addr and s_wdata are muxed from the granted master. When nothing is granted, these are 0.
- Lock: when s_req=1 and s_addr_ok=0, set lock=1 and lock_src=granted master. The grant cannot change until addr_ok.
- Accept (s_req & s_addr_ok):
  - Pulse addr_ok to the granted master only, in the same cycle (combinational pass-through).
  - Push the source id into the FIFO, clear lock, set rr_ptr to the other master.
  - Zero added latency on the address phase.
- Completion (s_data_ok & count!=0):
  - Pop the head; pulse data_ok to the head source in the same cycle.
  - s_rdata drives the head source's rdata; the other master's rdata=0.
- Simultaneous push and pop: count unchanged; head and tail pointers both advance, wrapping modulo MAX_OUTST.
- Full: count==MAX_OUTST forces s_req=0. There is no same-cycle bypass with a pop; the new request issues one cycle later.
- Stray completion: s_data_ok with count==0 is not routed (no data_ok to either master), sets err_stray_ok, and leaves the FIFO unchanged.
- Withdrawal: a master dropping req while locked violates the sram-like protocol. The arbiter keeps lock until addr_ok; no recovery is defined.
- Reset mid-operation: all in-flight tracking is discarded. cpu_axi_interface is reset together with this block, so no late data_ok is expected.

Decomposition:
- Shared package dmem_pkg holds:
  - src_id type, 1 bit: SRC_CACHED=0, SRC_UNCACHED=1.
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - default MAX_OUTST.
- Sub-module src_id_fifo: synchronous FIFO with parameters WIDTH=1 and DEPTH=MAX_OUTST.
  - Inputs: push, pop.
  - Outputs: head, count, full, empty.
  - Pointer wrap uses log2(DEPTH) bits; count uses log2(DEPTH)+1 bits.
- Top-level arbitration, lock and muxing are about 150 lines; the FIFO is about 60 lines.

Test Plan:
1. Single cached read: m0 addr=0x1FC0_0000 with s_addr_ok in the same cycle, s_data_ok 3 cycles later with rdata=0xDEAD_BEEF -> m0_addr_ok pulses in cycle 0, m0_data_ok pulses in cycle 3 with m0_rdata=0xDEAD_BEEF; m1 sees no pulses.
2. Contention: m0 and m1 request together after reset with PRIO_UNCACHED=1 -> m1 accepted first, m0 next cycle. Two data_oks return rdata 0x11 then 0x22 -> m1 gets 0x11, m0 gets 0x22.
3. Lock: m0 requests, s_addr_ok held 0 for 4 cycles while m1 also requests -> s_addr stays m0_addr for all 4 cycles; m0 accepted in cycle 4, then m1.
4. Full: issue 4 accepted writes with no s_data_ok -> 5th request sees s_req=0. A pop in cycle N lets s_req=1 in cycle N+1.
5. Simultaneous push and pop at count=2 -> count stays 2 and order is preserved across the pointer wrap (run 10 mixed transactions; data_ok sequence matches the acceptance order).
6. s_data_ok with the FIFO empty -> err_stray_ok=1 and held; resetn=0 for one edge clears it to 0 and leaves count=0.
